// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data memory responder (package mem_pkg).
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  localparam int WORD_BYTES = 4;
  localparam int BYTE_LANES = 4;
  localparam int OFS_W      = $clog2(WORD_BYTES);

  function automatic int idx_width(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  // Lane patterns a store may use when alignment checking is compiled in.
  function automatic logic be_legal(input logic [BYTE_LANES-1:0] be);
    case (be)
      4'b1111, 4'b0011, 4'b1100,
      4'b0001, 4'b0010, 4'b0100, 4'b1000: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store request and response channels between the memory-access stage and the data memory.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder_array.sv
// Single-port word RAM with byte-lane write enables and a registered read (read-before-write).
module data_mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = 8
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [BYTE_LANES-1:0] wr_be,
  input  logic [IDX_W-1:0]      idx,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < BYTE_LANES; i++) begin
        if (wr_be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder: one outstanding load/store, programmable wait states, held response.
// Optional alignment/byte-enable checking is compiled in with DATA_MEM_ALIGN_CHECK_EN.
//
// state | meaning
// IDLE  | req_ready=1, request latched on req_valid
// BUSY  | wait states counting down; last BUSY cycle drives the array access
// RESP  | rsp_valid=1, response held until rsp_ready
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);

  localparam int IDX_W = idx_width(DEPTH_WORDS);
  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  mem_state_t             state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic                   accept, commit;
  logic                   wr_q;
  logic [IDX_W-1:0]       idx_q;
  logic [31:0]            wdata_q;
  logic [BYTE_LANES-1:0]  be_q;
  logic [31:0]            ram_rdata;
  logic                   err_q;
  logic                   unused_addr;

  assign unused_addr = ^{bus.req_addr[31:IDX_W+OFS_W], bus.req_addr[OFS_W-1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        wr_q    <= bus.req_write;
        idx_q   <= bus.req_addr[OFS_W +: IDX_W];
        wdata_q <= bus.req_wdata;
        be_q    <= bus.req_be;
      end
    end
  end

`ifdef DATA_MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= (bus.req_addr[OFS_W-1:0] != '0) || (bus.req_write && !be_legal(bus.req_be));
    end
  end
`else
  assign err_q = 1'b0;
`endif

  // BUSY always lasts WAIT_STATES+1 cycles: the extra one feeds the registered array read.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          accept    = 1'b1;
          state_nxt = BUSY;
          cnt_nxt   = CNT_W'(WAIT_STATES);
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          commit    = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  data_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .en    (commit),
    .wr_be ((wr_q && !err_q) ? be_q : '0),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // The array output only changes on a commit, so it stays stable for the whole of RESP.
  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = (state == RESP && !wr_q && !err_q) ? ram_rdata : '0;
  assign bus.rsp_err   = (state == RESP) && err_q;

endmodule
